// File: rtl/uart_rcv_pkg.sv
// Shared types and sizing helpers for the UART receive control slice.
package uart_rcv_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, CHECK} state_t;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10;

  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic int count_width(input int data_bits);
    return $clog2(data_bits + 2);
  endfunction

endpackage

// File: rtl/rcv_timer.sv
// Up-counter with synchronous clear, enable and a programmable terminal value;
// it returns to zero when enabled while sitting on the terminal value.
module rcv_timer
  import uart_rcv_pkg::*;
#(
  parameter int WIDTH = timer_width(DEFAULT_CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  assign at_terminal = (count == terminal);

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= at_terminal ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/uart_rcv_ctrl.sv
// UART receive control: line synchronizer, start-bit qualification, bit timing,
// shift strobes for an external shift register, stop-bit check and status flags.
module uart_rcv_ctrl
  import uart_rcv_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   sr_data,
  input  logic                 data_read,
  output logic                 serial_sync,
  output logic                 shift_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 rx_busy
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam int CW = count_width(DATA_BITS);
  localparam logic [TW-1:0] HALF_TERM  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TERM  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_BITS);
  localparam logic [CW-1:0] FRAME_BITS = CW'(DATA_BITS + 1);

  state_t          state, next_state;
  logic            sync_meta, sync_prev;
  logic [TW-1:0]   timer_count, timer_term;
  logic            timer_clear, timer_en, timer_done;
  logic [CW-1:0]   bit_count;
  logic            bit_clear, frame_done, qualify;
  logic            frame_load, frame_good;

  // Synchronizer and edge-detect flops reset to the idle-high line level.
  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst) begin
      sync_meta   <= 1'b1;
      serial_sync <= 1'b1;
      sync_prev   <= 1'b1;
    end else begin
      sync_meta   <= serial_in;
      serial_sync <= sync_meta;
      sync_prev   <= serial_sync;
    end
  end

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  assign shift_enable = (state == DATA) && (timer_count == FULL_TERM);
  assign rx_busy      = (state != IDLE);

  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    timer_term  = FULL_TERM;
    bit_clear   = 1'b0;
    qualify     = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (sync_prev && !serial_sync)
          next_state = START;
      end
      START: begin
        timer_en   = 1'b1;
        timer_term = HALF_TERM;
        if (timer_done) begin
          if (serial_sync) begin
            next_state = IDLE;
          end else begin
            next_state  = DATA;
            timer_clear = 1'b1;
            bit_clear   = 1'b1;
            qualify     = 1'b1;
          end
        end
      end
      DATA: begin
        timer_en = 1'b1;
        if (shift_enable && (bit_count == LAST_BIT))
          next_state = CHECK;
      end
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  rcv_timer #(.WIDTH(TW)) u_bit_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (timer_clear),
    .enable      (timer_en),
    .terminal    (timer_term),
    .count       (timer_count),
    .at_terminal (timer_done)
  );

  rcv_timer #(.WIDTH(CW)) u_bit_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (bit_clear),
    .enable      (shift_enable),
    .terminal    (FRAME_BITS),
    .count       (bit_count),
    .at_terminal (frame_done)
  );

  assign frame_load = (state == CHECK) && frame_done;
  assign frame_good = frame_load && sr_data[DATA_BITS];

  // A good frame load takes priority over a coincident data_read.
  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '1;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (qualify)
        framing_error <= 1'b0;
      if (frame_good) begin
        rx_data       <= sr_data[DATA_BITS-1:0];
        data_ready    <= 1'b1;
        overrun_error <= !data_read && (overrun_error || data_ready);
      end else begin
        if (frame_load)
          framing_error <= 1'b1;
        if (data_read) begin
          data_ready    <= 1'b0;
          overrun_error <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rcv_ctrl.sv
// Directed bench for uart_rcv_ctrl with a 9-bit LSB-first shift register model.
module tb_uart_rcv_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_read = 1'b0;
  logic [8:0] sr_data;
  logic       serial_sync, shift_enable, data_ready, framing_error, overrun_error, rx_busy;
  logic [7:0] rx_data;

  int checks_total = 0;
  int checks_passed = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ready_cyc = -1;
  int shift_count = 0;
  int first_shift_cyc = -1;
  int last_shift_cyc = -1;
  logic dr_prev = 1'b0;

  uart_rcv_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .sr_data       (sr_data),
    .data_read     (data_read),
    .serial_sync   (serial_sync),
    .shift_enable  (shift_enable),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  // External shift register: new bit enters the MSB, so the stop bit lands in sr_data[8].
  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst)
      sr_data <= '1;
    else if (shift_enable)
      sr_data <= {serial_sync, sr_data[8:1]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (shift_enable) begin
      if (shift_count == 0) first_shift_cyc = cyc;
      last_shift_cyc = cyc;
      shift_count++;
    end
    if (data_ready && !dr_prev) ready_cyc = cyc;
    dr_prev = data_ready;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    wait_cycles(2);
    n_rst = 1'b1;
    wait_cycles(3);
  endtask

  // Line falls at posedge+1; the first edge sampling it is one cycle later.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic read_at_check);
    shift_count = 0;
    ready_cyc = -1;
    serial_in = 1'b0;
    fall_cyc = cyc;
    wait_cycles(10);
    for (int i = 0; i < 8; i++) begin
      serial_in = data[i];
      wait_cycles(10);
    end
    serial_in = stop;
    for (int k = 1; k <= 10; k++) begin
      wait_cycles(1);
      if (read_at_check && k == 8) data_read = 1'b1;
      if (k == 9) data_read = 1'b0;
    end
    serial_in = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    serial_in = 1'b1;
    #3;
    checks_total++;
    if ({serial_sync, shift_enable, data_ready, framing_error, overrun_error, rx_busy} !== 6'b100000)
      $display("[TB] FAIL reset_flags: got %b expected 100000",
               {serial_sync, shift_enable, data_ready, framing_error, overrun_error, rx_busy});
    else checks_passed++;
    checks_total++;
    if (rx_data !== 8'hFF) $display("[TB] FAIL reset_rx_data: got %h expected ff", rx_data);
    else checks_passed++;
    wait_cycles(2);
    n_rst = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    checks_total++;
    if (rx_data !== 8'hA5) $display("[TB] FAIL good_rx_data: got %h expected a5", rx_data);
    else checks_passed++;
    checks_total++;
    if (data_ready !== 1'b1 || framing_error !== 1'b0)
      $display("[TB] FAIL good_flags: got ready=%b ferr=%b expected ready=1 ferr=0", data_ready, framing_error);
    else checks_passed++;
    checks_total++;
    if (shift_count !== 9) $display("[TB] FAIL good_shift_count: got %0d expected 9", shift_count);
    else checks_passed++;
    checks_total++;
    if (last_shift_cyc - first_shift_cyc !== 80)
      $display("[TB] FAIL good_shift_spacing: got %0d expected 80", last_shift_cyc - first_shift_cyc);
    else checks_passed++;
    // 2 sync + 5 half bit + 90 bit periods + 1 check, from the first edge sampling the low line.
    checks_total++;
    if (ready_cyc - (fall_cyc + 1) !== 98)
      $display("[TB] FAIL good_latency: got %0d expected 98", ready_cyc - (fall_cyc + 1));
    else checks_passed++;
  endtask

  task automatic test_framing_error();
    apply_reset();
    send_frame(8'h5A, 1'b0, 1'b0);
    checks_total++;
    if (framing_error !== 1'b1 || data_ready !== 1'b0 || rx_busy !== 1'b0)
      $display("[TB] FAIL framing_flags: got ferr=%b ready=%b busy=%b expected 1 0 0",
               framing_error, data_ready, rx_busy);
    else checks_passed++;
    checks_total++;
    if (rx_data !== 8'hFF) $display("[TB] FAIL framing_rx_data: got %h expected ff", rx_data);
    else checks_passed++;
  endtask

  task automatic test_glitch();
    apply_reset();
    shift_count = 0;
    serial_in = 1'b0;
    wait_cycles(3);
    serial_in = 1'b1;
    checks_total++;
    if (rx_busy !== 1'b1) $display("[TB] FAIL glitch_busy: got %b expected 1", rx_busy);
    else checks_passed++;
    wait_cycles(10);
    checks_total++;
    if ({rx_busy, data_ready, framing_error, overrun_error} !== 4'b0000 || shift_count !== 0)
      $display("[TB] FAIL glitch_idle: got flags=%b shifts=%0d expected 0000 0",
               {rx_busy, data_ready, framing_error, overrun_error}, shift_count);
    else checks_passed++;
  endtask

  task automatic test_overrun();
    apply_reset();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    checks_total++;
    if (rx_data !== 8'h81 || overrun_error !== 1'b1 || data_ready !== 1'b1)
      $display("[TB] FAIL overrun_set: got %h oerr=%b ready=%b expected 81 1 1",
               rx_data, overrun_error, data_ready);
    else checks_passed++;
    data_read = 1'b1;
    wait_cycles(1);
    data_read = 1'b0;
    checks_total++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0)
      $display("[TB] FAIL overrun_clear: got ready=%b oerr=%b expected 0 0", data_ready, overrun_error);
    else checks_passed++;
  endtask

  task automatic test_read_on_check();
    apply_reset();
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h99, 1'b1, 1'b1);
    checks_total++;
    if (rx_data !== 8'h99 || data_ready !== 1'b1 || overrun_error !== 1'b0)
      $display("[TB] FAIL read_on_check: got %h ready=%b oerr=%b expected 99 1 0",
               rx_data, data_ready, overrun_error);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial;
    partial = 8'h6B;
    serial_in = 1'b0;
    wait_cycles(10);
    for (int i = 0; i < 4; i++) begin
      serial_in = partial[i];
      wait_cycles(10);
    end
    serial_in = partial[4];
    wait_cycles(5);
    n_rst = 1'b0;
    #1;
    checks_total++;
    if ({serial_sync, shift_enable, data_ready, framing_error, overrun_error, rx_busy} !== 6'b100000 ||
        rx_data !== 8'hFF)
      $display("[TB] FAIL midframe_reset: got flags=%b rx=%h expected 100000 ff",
               {serial_sync, shift_enable, data_ready, framing_error, overrun_error, rx_busy}, rx_data);
    else checks_passed++;
    serial_in = 1'b1;
    wait_cycles(2);
    n_rst = 1'b1;
    wait_cycles(3);
    send_frame(8'hC3, 1'b1, 1'b0);
    checks_total++;
    if (rx_data !== 8'hC3 || data_ready !== 1'b1 || framing_error !== 1'b0)
      $display("[TB] FAIL after_reset_frame: got %h ready=%b ferr=%b expected c3 1 0",
               rx_data, data_ready, framing_error);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_framing_error();
    test_glitch();
    test_overrun();
    test_read_on_check();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
